spi_rx_framer: RTL and testbench



---
 rtl/spi_proto_pkg.sv | 25 ++
 rtl/spi_frame_buf.sv | 39 +++
 rtl/spi_rx_framer.sv | 206 ++++++++++++++++++++
 tb/tb_spi_rx_framer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_proto_pkg.sv
// Shared SPI protocol constants: checksum seed, error codes,
// command bytes and the receive framer state encoding.
package spi_proto_pkg;

    localparam logic [7:0] SUM_SEED = 8'hCC;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_SUM     = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_TRUNC   = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;
    localparam logic [2:0] ERR_TRAIL   = 3'd5;

    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_RGBLED = 8'h02;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_SUM,
        S_DONE,
        S_DROP
    } state_e;

endpackage

// File: rtl/spi_frame_buf.sv
// Payload buffer: 2**ADDR_W x 8 RAM, single write port, registered read.
// Ports: clk, rst (sync, clears rdata only), we/waddr/wdata, raddr -> rdata.
module spi_frame_buf #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_q [2**ADDR_W];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_rx_framer.sv
// Parses received SPI bytes (LEN, payload, SUM) into checked frames.
// Ports: rx_valid/rx_data/rx_end in; frame_valid/frame_err pulses,
// err_code/err_sticky status, held frame (cmd, len, lock, rd port), busy.
module spi_rx_framer
    import spi_proto_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_end,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [2:0]        err_code,
    output logic              err_sticky,
    input  logic              err_clr,
    output logic [7:0]        frame_cmd,
    output logic [7:0]        frame_len,
    output logic              locked,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] sum_q, sum_d;
    logic       match_q, match_d;
    logic [2:0] pend_q, pend_d;
    logic [7:0] cmd_stage_q, cmd_stage_d;
    logic       frame_valid_q, frame_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [2:0] err_code_q, err_code_d;
    logic       err_sticky_q, err_sticky_d;
    logic       locked_q, locked_d;
    logic [7:0] frame_cmd_q, frame_cmd_d;
    logic [7:0] frame_len_q, frame_len_d;
    logic [2:0] err_new;
    logic       buf_we;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        sum_d         = sum_q;
        match_d       = match_q;
        pend_d        = pend_q;
        cmd_stage_d   = cmd_stage_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        err_sticky_d  = err_sticky_q;
        locked_d      = locked_q;
        frame_cmd_d   = frame_cmd_q;
        frame_len_d   = frame_len_q;
        err_new       = ERR_NONE;
        buf_we        = 1'b0;

        // Byte handling first; end handling then sees the updated state.
        if (rx_valid) begin
            unique case (state_q)
                S_LEN: begin
                    if (locked_q) begin
                        state_d = S_DROP;
                        pend_d  = ERR_OVERRUN;
                    end else if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                        state_d = S_DROP;
                        pend_d  = ERR_LEN;
                    end else begin
                        len_d   = rx_data;
                        cnt_d   = 8'h00;
                        sum_d   = SUM_SEED ^ rx_data;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    buf_we = !locked_q;
                    if (cnt_q == 8'h00) begin
                        cmd_stage_d = rx_data;
                    end
                    sum_d = sum_q ^ rx_data;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == len_q) begin
                        state_d = S_SUM;
                    end
                end
                S_SUM: begin
                    match_d = (rx_data == sum_q);
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_DROP;
                    pend_d  = ERR_TRAIL;
                end
                default: begin
                end
            endcase
        end

        if (rx_end) begin
            unique case (state_d)
                S_DONE: begin
                    if (match_d) begin
                        frame_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_new     = ERR_SUM;
                    end
                end
                S_DATA, S_SUM: begin
                    frame_err_d = 1'b1;
                    err_new     = ERR_TRUNC;
                end
                S_DROP: begin
                    frame_err_d = 1'b1;
                    err_new     = pend_d;
                end
                default: begin
                end
            endcase
            state_d = S_LEN;
        end

        // A rejection in the same cycle as err_clr must survive.
        if (err_clr) begin
            err_code_d   = ERR_NONE;
            err_sticky_d = 1'b0;
        end
        if (frame_err_d) begin
            err_code_d   = err_new;
            err_sticky_d = 1'b1;
        end

        if (frame_ack) begin
            locked_d = 1'b0;
        end
        if (frame_valid_d) begin
            locked_d    = 1'b1;
            frame_cmd_d = cmd_stage_d;
            frame_len_d = len_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q       <= S_LEN;
            len_q         <= 8'h00;
            cnt_q         <= 8'h00;
            sum_q         <= 8'h00;
            match_q       <= 1'b0;
            pend_q        <= ERR_NONE;
            cmd_stage_q   <= 8'h00;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            err_sticky_q  <= 1'b0;
            locked_q      <= 1'b0;
            frame_cmd_q   <= 8'h00;
            frame_len_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            match_q       <= match_d;
            pend_q        <= pend_d;
            cmd_stage_q   <= cmd_stage_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            err_sticky_q  <= err_sticky_d;
            locked_q      <= locked_d;
            frame_cmd_q   <= frame_cmd_d;
            frame_len_q   <= frame_len_d;
        end
    end

    spi_frame_buf #(
        .ADDR_W(ADDR_W)
    ) u_buf (
        .clk  (clk_in),
        .rst  (rst),
        .we   (buf_we),
        .waddr(cnt_q[ADDR_W-1:0]),
        .wdata(rx_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign err_sticky  = err_sticky_q;
    assign locked      = locked_q;
    assign frame_cmd   = frame_cmd_q;
    assign frame_len   = frame_len_q;
    assign busy        = (state_q != S_LEN);

endmodule

// File: tb/tb_spi_rx_framer.sv
// Testbench for spi_rx_framer: directed frames plus random transactions
// checked every cycle against a transaction-level model.
module tb_spi_rx_framer;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_end = 1'b0;
    logic       frame_valid;
    logic       frame_err;
    logic [2:0] err_code;
    logic       err_sticky;
    logic       err_clr = 1'b0;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic       locked;
    logic       frame_ack = 1'b0;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;
    logic       busy;

    int checks = 0;
    int failures = 0;

    spi_rx_framer #(
        .MAX_LEN(32),
        .ADDR_W (5)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_end     (rx_end),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .err_clr    (err_clr),
        .frame_cmd  (frame_cmd),
        .frame_len  (frame_len),
        .locked     (locked),
        .frame_ack  (frame_ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [7:0] txn[$];
    bit         first_locked;
    bit         model_ready = 0;
    bit         m_locked, m_sticky, m_fv, m_fe, m_busy;
    logic [7:0] m_cmd, m_len;
    logic [2:0] m_code;
    logic [7:0] held[32];
    int         held_len = 0;
    bit         m_rd_chk;
    logic [7:0] m_rd_exp;

    always @(posedge clk_in) begin : model
        int         n;
        int         l;
        logic [7:0] s;
        logic [2:0] code_new;
        if (rst) begin
            txn.delete();
            m_locked = 0; m_sticky = 0; m_fv = 0; m_fe = 0; m_busy = 0;
            m_cmd = 0; m_len = 0; m_code = 0;
            m_rd_chk = 1; m_rd_exp = 0;
            model_ready = 1;
        end else begin
            m_fv = 0; m_fe = 0; code_new = 0;
            if (rx_valid) begin
                if (txn.size() == 0) first_locked = m_locked;
                txn.push_back(rx_data);
            end
            if (rx_end && txn.size() != 0) begin
                n = txn.size();
                l = int'(txn[0]);
                if (first_locked) begin
                    m_fe = 1; code_new = 4;
                end else if (l == 0 || l > 32) begin
                    m_fe = 1; code_new = 2;
                end else if (n < l + 2) begin
                    m_fe = 1; code_new = 3;
                end else if (n > l + 2) begin
                    m_fe = 1; code_new = 5;
                end else begin
                    s = 8'hCC;
                    for (int i = 0; i <= l; i++) s = s ^ txn[i];
                    if (s == txn[l+1]) m_fv = 1;
                    else begin m_fe = 1; code_new = 1; end
                end
            end
            if (err_clr) begin m_code = 0; m_sticky = 0; end
            if (m_fe) begin m_code = code_new; m_sticky = 1; end
            if (frame_ack) m_locked = 0;
            if (m_fv) begin
                m_locked = 1;
                m_len = txn[0];
                m_cmd = txn[1];
                held_len = int'(txn[0]);
                for (int i = 0; i < held_len; i++) held[i] = txn[i+1];
            end
            if (rx_end) txn.delete();
            m_busy = (txn.size() != 0);
            m_rd_chk = m_locked && (int'(rd_addr) < held_len);
            m_rd_exp = held[rd_addr];
        end
    end

    always @(negedge clk_in) begin : compare
        if (model_ready) begin
            chk("frame_valid", frame_valid, m_fv);
            chk("frame_err", frame_err, m_fe);
            chk("err_code", err_code, m_code);
            chk("err_sticky", err_sticky, m_sticky);
            chk("locked", locked, m_locked);
            chk("frame_cmd", frame_cmd, m_cmd);
            chk("frame_len", frame_len, m_len);
            chk("busy", busy, m_busy);
            if (m_rd_chk) chk("rd_data", rd_data, m_rd_exp);
        end
    end

    // ---------------- stimulus ----------------
    bit         rand_mode = 0;
    logic [7:0] tx_q[$];

    task automatic step(input bit v, input logic [7:0] d, input bit e);
        rx_valid = v;
        rx_data  = d;
        rx_end   = e;
        if (rand_mode) begin
            frame_ack = ($urandom % 8) == 0;
            err_clr   = ($urandom % 12) == 0;
            rd_addr   = 5'($urandom);
        end
        @(posedge clk_in);
        #1;
        rx_valid  = 0;
        rx_end    = 0;
        frame_ack = 0;
        err_clr   = 0;
        rst       = 0;
    endtask

    task automatic send(input bit end_same);
        int n;
        n = tx_q.size();
        for (int i = 0; i < n; i++) begin
            step(1'b1, tx_q[i], end_same && (i == n - 1));
            if (rand_mode && ($urandom % 3) == 0) step(1'b0, 8'h00, 1'b0);
        end
        if (!end_same || n == 0) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic good_frame(input int l);
        logic [7:0] s;
        logic [7:0] b;
        tx_q.delete();
        tx_q.push_back(8'(l));
        s = 8'hCC ^ 8'(l);
        for (int i = 0; i < l; i++) begin
            b = 8'($urandom);
            tx_q.push_back(b);
            s = s ^ b;
        end
        tx_q.push_back(s);
    endtask

    initial begin
        rst = 1;
        @(posedge clk_in); #1;
        rst = 1;
        @(posedge clk_in); #1;
        rst = 0;
        chk("reset rd_data", rd_data, 8'h00);
        chk("reset locked", locked, 0);
        chk("reset busy", busy, 0);
        chk("reset err_code", err_code, 0);

        // 1: good frame, then buffer read
        tx_q = '{8'h02, 8'h01, 8'h05, 8'hCA};
        send(0);
        chk("t1 frame_valid", frame_valid, 1);
        chk("t1 frame_cmd", frame_cmd, 8'h01);
        chk("t1 frame_len", frame_len, 8'h02);
        chk("t1 locked", locked, 1);
        rd_addr = 5'd1;
        step(0, 0, 0);
        chk("t1 rd_data", rd_data, 8'h05);
        frame_ack = 1;
        step(0, 0, 0);
        chk("t1 ack", locked, 0);

        // 2: checksum mismatch, then clear
        tx_q = '{8'h02, 8'h01, 8'h05, 8'hCB};
        send(0);
        chk("t2 frame_err", frame_err, 1);
        chk("t2 err_code", err_code, 3'd1);
        chk("t2 sticky", err_sticky, 1);
        chk("t2 locked", locked, 0);
        err_clr = 1;
        step(0, 0, 0);
        chk("t2 clr sticky", err_sticky, 0);
        chk("t2 clr code", err_code, 0);

        // 3: bad lengths
        tx_q = '{8'h28, 8'hAA, 8'hBB, 8'hCC};
        send(0);
        chk("t3 long code", err_code, 3'd2);
        err_clr = 1;
        step(0, 0, 0);
        tx_q = '{8'h00};
        send(0);
        chk("t3 zero err", frame_err, 1);
        chk("t3 zero code", err_code, 3'd2);

        // 4: truncated, then 1-byte frame
        tx_q = '{8'h02, 8'h01};
        send(0);
        chk("t4 trunc code", err_code, 3'd3);
        tx_q = '{8'h01, 8'h07, 8'hCA};
        send(0);
        chk("t4 valid", frame_valid, 1);
        chk("t4 cmd", frame_cmd, 8'h07);
        frame_ack = 1;
        step(0, 0, 0);

        // 5: overrun while locked
        tx_q = '{8'h02, 8'h01, 8'h05, 8'hCA};
        send(0);
        tx_q = '{8'h01, 8'h09, 8'hC4};
        send(0);
        chk("t5 err", frame_err, 1);
        chk("t5 code", err_code, 3'd4);
        rd_addr = 5'd0;
        step(0, 0, 0);
        chk("t5 rd0", rd_data, 8'h01);
        rd_addr = 5'd1;
        step(0, 0, 0);
        chk("t5 rd1", rd_data, 8'h05);
        frame_ack = 1;
        step(0, 0, 0);
        chk("t5 ack", locked, 0);

        // 6: trailing byte; reset mid-frame
        tx_q = '{8'h02, 8'h01, 8'h05, 8'hCA, 8'h00};
        send(0);
        chk("t6 trail code", err_code, 3'd5);
        step(1, 8'h02, 0);
        step(1, 8'h01, 0);
        chk("t6 busy mid", busy, 1);
        rst = 1;
        step(0, 0, 0);
        chk("t6 busy rst", busy, 0);
        step(0, 0, 1);
        chk("t6 no err", frame_err, 0);
        chk("t6 no valid", frame_valid, 0);
        tx_q = '{8'h02, 8'h01, 8'h05, 8'hCA};
        send(1);
        chk("t6 clean", frame_valid, 1);
        frame_ack = 1;
        step(0, 0, 0);

        // random transactions
        rand_mode = 1;
        for (int t = 0; t < 300; t++) begin
            int kind;
            int l;
            kind = $urandom_range(0, 7);
            l = $urandom_range(1, 32);
            good_frame(l);
            case (kind)
                0, 1, 2: ;
                3: tx_q[l+1] = tx_q[l+1] ^ 8'(1 << $urandom_range(0, 7));
                4: begin
                    tx_q[0] = ($urandom % 2) ? 8'h00 : 8'($urandom_range(33, 255));
                    while (tx_q.size() > 4) void'(tx_q.pop_back());
                end
                5: begin
                    int keep;
                    keep = $urandom_range(1, l + 1);
                    while (tx_q.size() > keep) void'(tx_q.pop_back());
                end
                6: repeat ($urandom_range(1, 3)) tx_q.push_back(8'($urandom));
                default: tx_q.delete();
            endcase
            if (($urandom % 40) == 0 && tx_q.size() > 1) begin
                step(1, tx_q[0], 0);
                rst = 1;
                step(0, 0, 0);
            end else begin
                send(($urandom % 2) == 1);
            end
            repeat ($urandom_range(0, 3)) step(0, 0, 0);
        end
        rand_mode = 0;
        step(0, 0, 0);
        step(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
